// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Resolves memory freezes, taken-branch flushes and load-use stalls under a
// fixed priority, with a sticky stall watchdog.
// Optional macro PIPE_HAZARD_CTRL_PERF_EN adds stall/flush performance counters;
// when undefined, both perf outputs are tied to zero.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [3:0]  pr_we,
    output logic [3:0]  pr_nop,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int unsigned FC_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  wd_q;
    logic              timeout_q;
    logic              freeze;
    logic              load_use;

    assign freeze   = mem_req & ~mem_ready;
    assign load_use = ex_is_load & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

    // Flush state machine and flush-length counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Priority resolution: freeze > branch > flush > load-use > run
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_we   = 1'b1;
        pr_we   = 4'b1111;
        pr_nop  = 4'b0000;
        if (rst) begin
            pc_we  = 1'b0;
            pr_we  = 4'b0000;
        end else if (freeze) begin
            pc_we  = 1'b0;
            pr_we  = 4'b0000;
        end else if (ex_branch_taken) begin
            pr_nop = 4'b0011;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            end else begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        end else if (state_q == FLUSH) begin
            pr_nop = 4'b0001;
            fcnt_d = fcnt_q - FC_W'(1);
            if (fcnt_q == FC_W'(1)) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            pc_we  = 1'b0;
            pr_we  = 4'b1110;
            pr_nop = 4'b0010;
        end
    end

    // Watchdog: counts consecutive freeze cycles, sets a sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (freeze) begin
            if (wd_q < CNT_W'(MAX_STALL)) begin
                wd_q <= wd_q + CNT_W'(1);
            end
            if (wd_q >= CNT_W'(MAX_STALL - 1)) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wd_q <= '0;
        end
    end

    assign stall_timeout = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic        stall_inc;
    logic        flush_inc;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    assign stall_inc = freeze |
                       (load_use & ~ex_branch_taken & (state_q == RUN));
    assign flush_inc = ~freeze & (ex_branch_taken | (state_q == FLUSH));

    // Wrapping performance counters for effective stall and flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_inc) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_inc) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage CPU pipeline. It drives the load-enable and bubble-insert controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Resolves memory-wait freezes, taken-branch flushes and load-use stalls under a fixed priority.
- Sequential parts: a flush state machine, a flush-length counter and a stall watchdog.

Parameters:
- FLUSH_CYCLES, 1, number of cycles a NOP is injected into IF/ID after a taken branch (1..15).
- MAX_STALL, 64, consecutive freeze cycles before stall_timeout asserts (2..65535).
- CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- id_rs1  input  5  ID-stage source register 1
- id_rs2  input  5  ID-stage source register 2
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- ex_is_load  input  1  EX-stage instruction is a load
- ex_rd  input  5  EX-stage destination register
- ex_branch_taken  input  1  EX-stage branch/jump resolved taken
- mem_req  input  1  MEM stage has an outstanding data access
- mem_ready  input  1  data memory completes access this cycle
- pc_we  output  1  PC loads next value
- pr_we  output  4  per-register load enable; bit0=IF/ID, bit1=ID/EX, bit2=EX/MEM, bit3=MEM/WB
- pr_nop  output  4  per-register NOP-select; a register with pr_we=1 and pr_nop=1 loads a bubble
- stall_timeout  output  1  sticky watchdog flag
- perf_stall_cnt  output  32  freeze plus load-use stall cycles (see Optional Feature)
- perf_flush_cnt  output  32  flush cycles (see Optional Feature)

Behaviour:
- Reset (async): state=RUN, flush counter=0, watchdog=0, stall_timeout=0. While rst=1: pc_we=0, pr_we=4'b0000, pr_nop=4'b0000.
- All controls are combinational from the current state and inputs. The state and counters update on the clk rising edge.

Derived conditions:
- freeze = mem_req & ~mem_ready.
- load_use = ex_is_load & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).

Priority, highest first:
1. freeze: pc_we=0, pr_we=0000, pr_nop=0000. The state machine and flush counter hold.
2. ex_branch_taken, any state: pc_we=1, pr_we=1111, pr_nop=0011. Next state is FLUSH with counter=FLUSH_CYCLES-1, or stays RUN if FLUSH_CYCLES=1. A branch taken while in FLUSH restarts the counter.
3. state FLUSH: pc_we=1, pr_we=1111, pr_nop=0001. The counter decrements; at counter==1 the next state is RUN. load_use is ignored in FLUSH.
4. load_use (RUN only): pc_we=0, pr_we=1110, pr_nop=0010. IF/ID holds and a bubble enters ID/EX. Lasts one cycle by construction, because the load advances to MEM.
5. Otherwise: pc_we=1, pr_we=1111, pr_nop=0000.

Freeze and branch interaction:
- A branch during freeze is deferred. EX holds, so ex_branch_taken remains asserted and is acted on in the first unfrozen cycle.

Watchdog:
- Increments each freeze cycle and clears on any non-freeze cycle. It saturates at MAX_STALL.
- When the count reaches MAX_STALL, stall_timeout is set and stays 1 until rst.

Reset mid-operation:
- An asserted rst during FLUSH or freeze returns immediately to the reset values. There is no partial flush after release.

Optional Feature:
Macro PIPE_HAZARD_CTRL_PERF_EN.
- Defined: two 32-bit wrapping counters, reset to 0.
  - perf_stall_cnt increments on every freeze or load_use cycle.
  - perf_flush_cnt increments on every branch-taken cycle and every FLUSH cycle.
- Undefined: no counter flops; both outputs are tied to 32'd0. Ports remain present.

Test Plan:
1. Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for 1 cycle -> pc_we=0, pr_we=1110, pr_nop=0010 that cycle; next cycle with ex_is_load=0 -> pr_we=1111, pr_nop=0000. With ex_rd=0 -> no stall.
2. Branch flush, FLUSH_CYCLES=3: ex_branch_taken pulse -> cycle0 pr_nop=0011; cycles 1-2 pr_nop=0001; cycle3 pr_nop=0000 in RUN. Second branch in cycle1 -> two further 0001 cycles follow it.
3. Freeze: mem_req=1, mem_ready=0 for 4 cycles with ex_branch_taken=1 -> pr_we=0000, pc_we=0 throughout; the cycle mem_ready=1 -> pr_nop=0011.
4. Priority: freeze, branch and load_use asserted together -> freeze outputs. Branch and load_use together -> branch outputs.
5. Watchdog, MAX_STALL=8: 8 freeze cycles -> stall_timeout=1 after the 8th edge and sticky after the freeze ends. 7 freeze cycles, 1 free cycle, 7 freeze cycles -> stall_timeout stays 0.
6. Reset and perf counters: rst asserted mid-FLUSH -> immediate pr_we=0000, pc_we=0, state RUN after release. With PIPE_HAZARD_CTRL_PERF_EN, 3 load-use plus 2 freeze cycles -> perf_stall_cnt=5; without the macro -> both counters read 0.
